// File: rtl/snn_reward_core.sv
// snn_reward_core: two-layer spiking core with reward-modulated
// weight learning (IDLE -> ACCUM -> FIRE -> optional LEARN).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready sample handshake, in_data = N_IN x DW activations
//   learn_en          sampled in FIRE, selects LEARN afterwards
//   reward_valid/pos  reward strobe (pos=1 reward, pos=0 punish)
//   out_valid         one-cycle strobe for out_spikes / out_sum
//   w_addr/w_data     combinational weight read-back (i*N_OUT+j)
module snn_reward_core #(
    parameter  int N_IN        = 2,
    parameter  int N_OUT       = 2,
    parameter  int DW          = 8,
    parameter  int WW          = 5,
    parameter  int THRESH_IN   = 1,
    parameter  int THRESH_OUT  = 1,
    parameter  int W_INIT      = 0,
    parameter  int RWD_TIMEOUT = 16,
    localparam int NW          = N_IN * N_OUT,
    localparam int AW          = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*DW-1:0]    in_data,
    input  logic                  learn_en,
    input  logic                  reward_valid,
    input  logic                  reward_pos,
    output logic                  out_valid,
    output logic [N_OUT-1:0]      out_spikes,
    output logic [N_OUT*DW-1:0]   out_sum,
    input  logic [AW-1:0]         w_addr,
    output logic [WW-1:0]         w_data
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW = $clog2(RWD_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FIRE  = 2'd2;
    localparam logic [1:0] S_LEARN = 2'd3;

    localparam logic [DW-1:0] TIN  = DW'(THRESH_IN);
    localparam logic [DW-1:0] TOUT = DW'(THRESH_OUT);

    localparam logic signed [WW-1:0] WMAX = {1'b0, {(WW-1){1'b1}}};
    localparam logic signed [WW-1:0] WMIN = {1'b1, {(WW-1){1'b0}}};

    logic [1:0]              r_state;
    logic [N_IN*DW-1:0]      r_x;
    logic [N_IN-1:0]         r_pre;
    logic [DW-1:0]           r_acc [N_OUT];
    logic [IW-1:0]           r_idx;
    logic [CW-1:0]           r_cnt;
    logic [N_OUT-1:0]        r_post;
    logic [N_OUT*DW-1:0]     r_sum;
    logic                    r_ov;
    logic signed [WW-1:0]    r_w [NW];

    logic [N_IN-1:0]         w_pre_in;
    logic [DW-1:0]           w_acc_nxt [N_OUT];
    logic [N_OUT-1:0]        w_post;
    logic [N_OUT*DW-1:0]     w_sum;
    logic signed [WW-1:0]    w_w_upd [NW];

    function automatic logic [DW-1:0] f_sat_add(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DW] ? '1 : s[DW-1:0];
    endfunction

    // Positive weights scale up (saturating when any bit falls off),
    // negative weights scale down; huge magnitudes collapse to sat/0.
    function automatic logic [DW-1:0] f_shift(
        input logic [DW-1:0]        x,
        input logic signed [WW-1:0] w
    );
        int              wi;
        logic [2*DW-1:0] wide;
        logic [DW-1:0]   res;
        wi   = int'(w);
        wide = '0;
        res  = '0;
        if (wi >= 0) begin
            if (wi >= DW) begin
                res = (x != '0) ? '1 : '0;
            end else begin
                wide = {{DW{1'b0}}, x} << wi;
                res  = (wide[2*DW-1:DW] != '0) ? '1 : wide[DW-1:0];
            end
        end else if (-wi >= DW) begin
            res = '0;
        end else begin
            res = x >> (-wi);
        end
        return res;
    endfunction

    function automatic logic signed [WW-1:0] f_inc(
        input logic signed [WW-1:0] w
    );
        return (w == WMAX) ? WMAX : w + WW'(1);
    endfunction

    function automatic logic signed [WW-1:0] f_dec(
        input logic signed [WW-1:0] w
    );
        return (w == WMIN) ? WMIN : w - WW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_pre_in[i] = in_data[i*DW +: DW] > TIN;
        end
    end

    // Only the channel selected by r_idx contributes this cycle.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            w_acc_nxt[j] = r_acc[j];
        end
        for (int i = 0; i < N_IN; i++) begin
            if ((IW'(i) == r_idx) && r_pre[i]) begin
                for (int j = 0; j < N_OUT; j++) begin
                    w_acc_nxt[j] = f_sat_add(
                        r_acc[j],
                        f_shift(r_x[i*DW +: DW], r_w[i*N_OUT+j]));
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_post[j] = r_acc[j] > TOUT;
            if (w_post[j]) begin
                w_sum[j*DW +: DW] = r_acc[j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            for (int j = 0; j < N_OUT; j++) begin
                w_w_upd[i*N_OUT+j] = r_w[i*N_OUT+j];
                if (r_post[j]) begin
                    if (reward_pos) begin
                        w_w_upd[i*N_OUT+j] = r_pre[i]
                            ? f_inc(r_w[i*N_OUT+j])
                            : f_dec(r_w[i*N_OUT+j]);
                    end else if (r_pre[i]) begin
                        w_w_upd[i*N_OUT+j] = f_dec(r_w[i*N_OUT+j]);
                    end
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int k = 0; k < NW; k++) begin
            if (AW'(k) == w_addr) begin
                w_data = r_w[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_pre   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_post  <= '0;
            r_sum   <= '0;
            r_ov    <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                r_acc[j] <= '0;
            end
            for (int k = 0; k < NW; k++) begin
                r_w[k] <= WW'(W_INIT);
            end
        end else begin
            r_ov <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_data;
                        r_pre   <= w_pre_in;
                        r_idx   <= '0;
                        r_state <= S_ACCUM;
                        for (int j = 0; j < N_OUT; j++) begin
                            r_acc[j] <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        r_acc[j] <= w_acc_nxt[j];
                    end
                    if (r_idx == IW'(N_IN - 1)) begin
                        r_state <= S_FIRE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_FIRE: begin
                    r_post  <= w_post;
                    r_sum   <= w_sum;
                    r_ov    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= learn_en ? S_LEARN : S_IDLE;
                end
                S_LEARN: begin
                    // Reward wins over expiry in the final wait cycle.
                    if (reward_valid) begin
                        for (int k = 0; k < NW; k++) begin
                            r_w[k] <= w_w_upd[k];
                        end
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == CW'(RWD_TIMEOUT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_ov;
    assign out_spikes = r_post;
    assign out_sum    = r_sum;

endmodule

// File: tb/tb_snn_reward_core.sv
// tb_snn_reward_core: randomized scoreboard bench for snn_reward_core
// with a behavioural reference model of inference and learning.
module tb_snn_reward_core;

    localparam int NI = 2;
    localparam int NO = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        learn_en = 1'b0;
    logic        reward_valid = 1'b0;
    logic        reward_pos = 1'b0;
    logic        out_valid;
    logic [1:0]  out_spikes;
    logic [15:0] out_sum;
    logic [1:0]  w_addr = '0;
    logic [4:0]  w_data;

    snn_reward_core dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .learn_en     (learn_en),
        .reward_valid (reward_valid),
        .reward_pos   (reward_pos),
        .out_valid    (out_valid),
        .out_spikes   (out_spikes),
        .out_sum      (out_sum),
        .w_addr       (w_addr),
        .w_data       (w_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  sp;
        logic [15:0] sm;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   wm[NI*NO];
    int   mpre[NI];
    int   mpost[NO];

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic int mshift(input int x, input int w);
        longint v;
        v = x;
        if (w >= 0) begin
            for (int k = 0; k < w; k++) v = v * 2;
            return (v > 255) ? 255 : int'(v);
        end
        for (int k = 0; k < -w; k++) v = v / 2;
        return int'(v);
    endfunction

    function automatic int clampw(input int w);
        if (w > 15) return 15;
        if (w < -16) return -16;
        return w;
    endfunction

    // Monitor: pops an expectation on each out_valid, and checks that
    // outputs hold between strobes.
    initial begin
        exp_t        e;
        logic [1:0]  h_sp;
        logic [15:0] h_sm;
        h_sp = '0;
        h_sm = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                h_sp = '0;
                h_sm = '0;
            end else if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", int'(out_valid), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("spikes", int'(out_spikes), int'(e.sp));
                    chk("sum", int'(out_sum), int'(e.sm));
                    chk("latency", cyc - e.cyc, NI + 1);
                end
                h_sp = out_spikes;
                h_sm = out_sum;
            end else begin
                chk("hold_spikes", int'(out_spikes), int'(h_sp));
                chk("hold_sum", int'(out_sum), int'(h_sm));
            end
        end
    end

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", int'(in_ready), 1);
    endtask

    task automatic check_weights();
        for (int a = 0; a < NI*NO; a++) begin
            w_addr = a[1:0];
            #1;
            chk($sformatf("weight%0d", a), int'($signed(w_data)), wm[a]);
        end
    endtask

    // mode: 0 no reward, 1 reward, 2 punish; d = LEARN cycles before pulse
    task automatic do_sample(input int x0, input int x1, input bit learn,
                             input int mode, input int d);
        bit   ok;
        exp_t e;
        int   xs[NI];
        int   acc[NO];
        wait_idle(ok);
        if (!ok) return;
        xs[0] = x0;
        xs[1] = x1;
        for (int j = 0; j < NO; j++) acc[j] = 0;
        for (int i = 0; i < NI; i++) begin
            mpre[i] = (xs[i] > 1) ? 1 : 0;
            if (mpre[i] == 1) begin
                for (int j = 0; j < NO; j++) begin
                    acc[j] = acc[j] + mshift(xs[i], wm[i*NO+j]);
                    if (acc[j] > 255) acc[j] = 255;
                end
            end
        end
        e.sp = '0;
        e.sm = '0;
        for (int j = 0; j < NO; j++) begin
            mpost[j] = (acc[j] > 1) ? 1 : 0;
            e.sp[j] = (mpost[j] == 1);
            if (mpost[j] == 1) e.sm[j*8 +: 8] = acc[j][7:0];
        end
        in_data  = {x1[7:0], x0[7:0]};
        learn_en = learn;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.cyc = cyc;
        sbq.push_back(e);
        in_data = 16'($urandom);
        @(posedge clk);
        #1;
        in_data = 16'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        if (mode != 0) begin
            repeat (d) begin
                @(posedge clk);
                #1;
            end
            reward_pos   = (mode == 1);
            reward_valid = 1'b1;
            @(posedge clk);
            #1;
            reward_valid = 1'b0;
            if (learn && d < TO) begin
                for (int i = 0; i < NI; i++) begin
                    for (int j = 0; j < NO; j++) begin
                        if (mpost[j] == 1) begin
                            if (mode == 1) begin
                                wm[i*NO+j] = clampw(wm[i*NO+j] +
                                    ((mpre[i] == 1) ? 1 : -1));
                            end else if (mpre[i] == 1) begin
                                wm[i*NO+j] = clampw(wm[i*NO+j] - 1);
                            end
                        end
                    end
                end
            end
        end
        learn_en = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        int x0;
        int x1;
        for (int k = 0; k < NI*NO; k++) wm[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_spikes", int'(out_spikes), 0);
        chk("rst_sum", int'(out_sum), 0);
        check_weights();

        do_sample(2, 3, 1'b0, 0, 0);
        do_sample(2, 3, 1'b1, 1, 2);
        wait_idle(ok);
        check_weights();
        do_sample(2, 3, 1'b0, 0, 0);

        do_sample(1, 1, 1'b1, 1, 0);
        wait_idle(ok);
        check_weights();

        do_sample(2, 3, 1'b1, 0, 0);
        n = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            n++;
            if (in_ready) break;
        end
        chk("timeout_len", n, TO + 1);
        check_weights();
        reward_pos   = 1'b1;
        reward_valid = 1'b1;
        @(posedge clk);
        #1;
        reward_valid = 1'b0;
        check_weights();

        do_sample(2, 3, 1'b1, 1, TO - 1);
        wait_idle(ok);
        check_weights();
        do_sample(2, 3, 1'b1, 2, TO);
        wait_idle(ok);
        check_weights();

        for (int r = 0; r < 20; r++) do_sample(200, 0, 1'b1, 1, 0);
        wait_idle(ok);
        check_weights();

        for (int r = 0; r < 40; r++) begin
            x0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 255));
            x1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 255));
            do_sample(x0, x1, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)),
                      int'($urandom_range(0, TO + 1)));
            wait_idle(ok);
            check_weights();
        end

        wait_idle(ok);
        in_data  = {8'd5, 8'd9};
        learn_en = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        learn_en = 1'b0;
        for (int k = 0; k < NI*NO; k++) wm[k] = 0;
        @(negedge clk);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_spikes", int'(out_spikes), 0);
        chk("abort_sum", int'(out_sum), 0);
        check_weights();

        do_sample(2, 3, 1'b0, 0, 0);
        wait_idle(ok);
        repeat (5) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snn_reward_core.md
SNN_REWARD_CORE -- requirements
Module: snn_reward_core

Interface
REQ-001 Parameter N_IN, default 2, number of presynaptic input channels.
REQ-002 Parameter N_OUT, default 2, number of output neurons.
REQ-003 Parameter DW, default 8, unsigned activation and accumulator width per channel.
REQ-004 Parameter WW, default 5, signed two's-complement weight width; WMAX=2^(WW-1)-1, WMIN=-2^(WW-1).
REQ-005 Parameters THRESH_IN and THRESH_OUT, default 1; a spike requires a value strictly greater than the threshold.
REQ-006 Parameter W_INIT, default 0, reset value of every weight; parameter RWD_TIMEOUT, default 16, LEARN wait limit in cycles.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 rst  in  1  reset; synchronous, active-high.
REQ-009 in_valid / in_ready  in / out  1 / 1  sample handshake; transfer occurs when both are 1 on a rising edge.
REQ-010 in_data  in  N_IN*DW  input activations; channel i is bits [i*DW +: DW].
REQ-011 learn_en  in  1  sampled in FIRE; selects whether LEARN follows.
REQ-012 reward_valid / reward_pos  in / in  1 / 1  reward strobe; reward_pos=1 reward, 0 punish.
REQ-013 out_valid  out  1  one-cycle strobe qualifying out_spikes and out_sum.
REQ-014 out_spikes / out_sum  out / out  N_OUT / N_OUT*DW  post-spike flags and gated sums; out_sum[j] is bits [j*DW +: DW].
REQ-015 w_addr / w_data  in / out  clog2(N_IN*N_OUT) / WW  combinational weight read-back; index = i*N_OUT+j; out-of-range index returns 0.

Function
REQ-016 FSM states SHALL be IDLE, ACCUM, FIRE, LEARN; in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on handshake, latch in_data, set pre[i]=(x_i>THRESH_IN), clear all acc[j], set channel index to 0, enter ACCUM.
REQ-018 ACCUM: one channel per cycle, N_IN cycles; if pre[i], each acc[j] += shift(x_i, w[i][j]); afterwards enter FIRE.
REQ-019 shift(x,w): w>=0 gives x<<w saturated to 2^DW-1 if any bit is lost; w<0 gives x>>(-w); a magnitude >=DW gives saturation (w>0, x!=0) or 0 (w<0).
REQ-020 Accumulator addition SHALL saturate at 2^DW-1 and SHALL never wrap.
REQ-021 FIRE (one cycle): post[j]=(acc[j]>THRESH_OUT); out_sum[j]=post[j]?acc[j]:0; out_valid=1; next state is LEARN if learn_en, else IDLE.
REQ-022 out_spikes and out_sum SHALL hold their values until the next FIRE; out_valid SHALL be 1 only in the cycle following FIRE entry.
REQ-023 Latency: handshake at edge T gives out_valid high in the cycle after edge T+N_IN+1.
REQ-024 LEARN: wait up to RWD_TIMEOUT cycles for reward_valid; on expiry, return to IDLE with no weight change.
REQ-025 On reward_valid in LEARN, for every j with post[j]=1: reward_pos=1 gives w[i][j]+1 if pre[i], else w[i][j]-1; reward_pos=0 gives w[i][j]-1 if pre[i], else unchanged; then return to IDLE.
REQ-026 Weights with post[j]=0 SHALL be unchanged; updates SHALL saturate at WMAX/WMIN and never wrap.
REQ-027 reward_valid outside LEARN SHALL be ignored; in_valid outside IDLE SHALL NOT be accepted, and in_data SHALL NOT be sampled.
REQ-028 A reward_valid arriving in the same cycle as timeout expiry SHALL be honoured (update applied).

Reset
REQ-029 While rst=1 at an edge: state=IDLE, all weights=W_INIT, acc/pre/post=0, out_valid=0, out_spikes=0, out_sum=0, timeout counter=0.
REQ-030 Reset asserted mid-ACCUM or mid-LEARN SHALL abort the operation; no partial weight update survives, and in_ready=1 in the cycle after rst falls.

Verification
REQ-031 Defaults, W_INIT=0, in_data={8'd3,8'd2}, learn_en=0 -> out_valid 3 cycles after handshake; acc=5 each; out_spikes=2'b11; out_sum={8'd5,8'd5}.
REQ-032 Same input, learn_en=1, reward_valid reward_pos=1 in LEARN -> all four weights read back as +1; repeat the sample -> out_sum={8'd10,8'd10}.
REQ-033 Force w[0][0]=WMAX via 20 rewarded samples with x0=8'd200 -> acc[0] saturates at 255; weight read-back stays 15; no wrap.
REQ-034 in_data={8'd1,8'd1} (no pre-spikes) -> out_spikes=0, out_sum=0; LEARN with reward_pos=1 -> weights unchanged.
REQ-035 learn_en=1 with no reward for 16 cycles -> IDLE, in_ready=1, weights unchanged; reward_valid pulsed in IDLE -> ignored.
REQ-036 rst asserted in the 2nd ACCUM cycle -> next cycle out_valid=0, in_ready=1, all weights=W_INIT.
